// File: rtl/core_decode_queue.sv
// Fetch-to-execute instruction queue with opcode pre-decode.
// Replays two-phase AMOs by holding the head entry for a second handshake.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   flush             sync flush of all entries and the phase
//   in_valid/in_ready fetch handshake; in_instr, in_pc entry payload
//   out_valid/out_ready execute handshake on the current head phase
//   out_instr, out_pc head payload (NOP/0 when empty)
//   out_phase, out_last phase of head, final-phase flag
//   out_class, out_illegal pre-decode class and illegality
//   count             occupied entries
module core_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_phase,
  output logic                       out_last,
  output logic [2:0]                 out_class,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            phase;

  logic        push;
  logic        pop;
  logic        hs;
  logic [31:0] head_i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  f5;
  logic [2:0]  cls;
  logic        f5_ok;
  logic        ill;
  logic        two;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign pop       = hs & out_last;

  assign head_i = instr_q[rptr];
  assign op     = head_i[6:0];
  assign f3     = head_i[14:12];
  assign f5     = head_i[31:27];

  always_comb begin
    cls = 3'd7;
    unique case (1'b1)
      (op == 7'b0110011) || (op == 7'b0010011) ||
      (op == 7'b0110111) || (op == 7'b0010111): cls = 3'd0;
      (op == 7'b1100011) || (op == 7'b1101111) ||
      (op == 7'b1100111):                       cls = 3'd1;
      (op == 7'b0000011):                       cls = 3'd2;
      (op == 7'b0100011):                       cls = 3'd3;
      (op == 7'b0101111):                       cls = 3'd4;
      (op == 7'b1110011):                       cls = 3'd5;
      (op == 7'b0001111):                       cls = 3'd6;
      default:                                  cls = 3'd7;
    endcase
  end

  always_comb begin
    f5_ok = 1'b0;
    case (f5)
      5'b00010, 5'b00011, 5'b00001, 5'b00000,
      5'b00100, 5'b01100, 5'b01000, 5'b10000,
      5'b10100, 5'b11000, 5'b11100: f5_ok = 1'b1;
      default:                      f5_ok = 1'b0;
    endcase
  end

  assign ill = (cls == 3'd7) ||
               ((cls == 3'd4) && ((f3 != 3'b010) || !f5_ok));

  // LR/SC are not read-modify-write, so they stay single-phase
  assign two = out_valid && (cls == 3'd4) && !ill &&
               (f5 != 5'b00010) && (f5 != 5'b00011);

  assign out_instr   = out_valid ? head_i : 32'h0000_0013;
  assign out_pc      = out_valid ? pc_q[rptr] : '0;
  assign out_class   = out_valid ? cls : 3'd0;
  assign out_illegal = out_valid & ill;
  assign out_phase   = out_valid & phase;
  assign out_last    = ~two | phase;
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q[wptr] <= in_instr;
      pc_q[wptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (pop)            phase <= 1'b0;
      else if (hs && two) phase <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_decode_queue.sv
// Scoreboard bench for core_decode_queue.
// Directed pushes queue expected phases; a monitor checks each handshake.
module tb_core_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_phase;
  logic        out_last;
  logic [2:0]  out_class;
  logic        out_illegal;
  logic [2:0]  count;

  core_decode_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_phase(out_phase), .out_last(out_last),
    .out_class(out_class), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ph;
    logic        last;
    logic [2:0]  cls;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_a;
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_a = {out_instr, out_pc, out_phase, out_last,
               out_class, out_illegal};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got %h want nothing", mon_a);
      end else begin
        mon_e = sb.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL sb_entry: got %h want %h", mon_a, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] i, input logic [31:0] p,
                          input logic [2:0] c, input logic il,
                          input logic two);
    if (two) begin
      sb.push_back({i, p, 1'b0, 1'b0, c, il});
      sb.push_back({i, p, 1'b1, 1'b1, c, il});
    end else begin
      sb.push_back({i, p, 1'b0, 1'b1, c, il});
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p,
                      input logic [2:0] c, input logic il,
                      input logic two);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = i;
    in_pc = p;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_push(i, p, c, il, two);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 want 1");
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_instr", out_instr, 32'h13);
    chk("rst_pc", out_pc, 0);
    chk("rst_last", out_last, 1);
    chk("rst_misc", {out_phase, out_class, out_illegal}, 0);

    push(32'h0010_0093, 32'h100, 3'd0, 1'b0, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", count, 1);
    chk("t1_class", out_class, 0);
    chk("t1_last", out_last, 1);
    chk("t1_pc", out_pc, 32'h100);
    drain(1);
    chk("t1_count0", count, 0);
    chk("t1_valid0", out_valid, 0);

    push(32'h0000_A083, 32'h200, 3'd2, 1'b0, 1'b0);
    push(32'h0010_A023, 32'h204, 3'd3, 1'b0, 1'b0);
    push(32'h0000_006F, 32'h208, 3'd1, 1'b0, 1'b0);
    push(32'h0000_000F, 32'h20C, 3'd6, 1'b0, 1'b0);
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_instr = 32'h0000_0073;
    in_pc = 32'h210;
    tick();
    chk("full_hold", count, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_count", count, 3);
    chk("full_pop_ready", in_ready, 1);
    exp_push(32'h0000_0073, 32'h210, 3'd5, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("full_refill", count, 4);
    drain(4);
    chk("wrap_empty", count, 0);

    push(32'h00B5_A52F, 32'h300, 3'd4, 1'b0, 1'b1);
    push(32'h1005_A52F, 32'h304, 3'd4, 1'b0, 1'b0);
    out_ready = 1'b1;
    chk("amo_ph0", {out_phase, out_last}, 2'b00);
    tick();
    chk("amo_ph1", {out_phase, out_last}, 2'b11);
    chk("amo_pc", out_pc, 32'h300);
    tick();
    chk("lr_single", {out_phase, out_last}, 2'b01);
    chk("lr_pc", out_pc, 32'h304);
    tick();
    out_ready = 1'b0;
    chk("amo_empty", count, 0);

    push(32'h0000_007F, 32'h400, 3'd7, 1'b1, 1'b0);
    push(32'h00B5_B52F, 32'h404, 3'd4, 1'b1, 1'b0);
    push(32'hF8B5_A52F, 32'h408, 3'd4, 1'b1, 1'b0);
    chk("ill_head", {out_class, out_illegal, out_last}, 5'b11111);
    drain(3);
    chk("ill_empty", count, 0);

    push(32'h0050_0093, 32'h500, 3'd0, 1'b0, 1'b0);
    push(32'h0060_0093, 32'h504, 3'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h0070_0093;
    in_pc = 32'h508;
    out_ready = 1'b1;
    exp_push(32'h0070_0093, 32'h508, 3'd0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("simul_count", count, 2);
    drain(2);
    chk("simul_empty", count, 0);

    push(32'h0080_0093, 32'h600, 3'd0, 1'b0, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0090_0093;
    in_pc = 32'h604;
    chk("flush_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    tick();
    chk("flush_nopush", {out_valid, count}, 0);
    chk("flush_instr", out_instr, 32'h13);

    push(32'h00B5_A52F, 32'h700, 3'd4, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fa_phase1", out_phase, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("fa_valid", out_valid, 0);
    chk("fa_phase", out_phase, 0);
    push(32'h00B5_A52F, 32'h704, 3'd4, 1'b0, 1'b1);
    chk("fa_restart", {out_phase, out_last}, 2'b00);
    drain(2);
    chk("fa_empty", count, 0);

    push(32'h00B5_A52F, 32'h800, 3'd4, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ra_phase1", out_phase, 1);
    rst_n = 1'b0;
    #1;
    chk("ra_phase0", {out_valid, out_phase, count}, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ra_ready", in_ready, 1);
    chk("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_decode_queue.md
# core_decode_queue

Instruction queue and phase sequencer that sits between fetch and the execute-stage decoder. It buffers up to DEPTH fetched instructions with their PCs and presents the head entry to execute over a valid/ready handshake. It pre-classifies each head instruction and flags opcode-level illegality. It replays atomic read-modify-write AMOs as two phases, generating the exec phase itself instead of taking it as an input.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥ 2
- XLEN, 32, PC width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous queue flush (redirect/trap)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts (= not full)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry available
- out_ready  in  1  execute consumes current phase
- out_instr  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_phase  out  1  exec phase of head (0 first, 1 second)
- out_last  out  1  current phase is final; pop occurs on handshake
- out_class  out  3  pre-decode class (see Operation)
- out_illegal  out  1  opcode-level illegal
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer of {instr, pc}; write/read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter.
- Push: in_valid & in_ready. Pop: out_valid & out_ready & out_last.
- in_ready = (count != DEPTH); no same-cycle pass-through when full, even if popping.
- Class from instr[6:0]:
  - 0 ALU: 0110011, 0010011, 0110111, 0010111
  - 1 CTRL: 1100011, 1101111, 1100111
  - 2 LOAD: 0000011
  - 3 STORE: 0100011
  - 4 AMO: 0101111
  - 5 SYSTEM: 1110011
  - 6 MISCMEM: 0001111
  - 7 any other opcode
- out_illegal = class 7, or (class 4 and funct3 != 010), or (class 4 and funct5 = instr[31:27] not in {00010, 00011, 00001, 00000, 00100, 01100, 01000, 10000, 10100, 11000, 11100}).
- Two-phase AMO: class 4, not illegal, and funct5 not LR (00010) or SC (00011).
- Every other entry, including illegal ones, is single-phase.
- Phase register:
  - Reset value 0.
  - Handshake on a two-phase entry with phase 0: phase goes to 1 and the entry stays.
  - Pop: phase goes to 0.
- out_last = ~two_phase | phase.
- out_instr, out_pc, out_class, out_illegal and out_phase are stable across both phases of an AMO.
- When out_valid = 0, the outputs are defined: out_instr = 32'h00000013, out_pc = 0, out_class = 0, out_illegal = 0, out_phase = 0, out_last = 1.
- flush:
  - Sets pointers, count and phase to 0 next cycle.
  - Wins over a same-cycle push and pop; the pushed entry is discarded.
  - in_ready is unaffected during the flush cycle.

## Timing
- Reset (async, rst_n low):
  - Pointers, count and phase are 0.
  - out_valid = 0, in_ready = 1, defaults as above.
- Push to out_valid: 1 cycle. Entries are registered and there is no combinational bypass.
- out_* are combinational from head storage and the phase register. in_ready is a function of count only.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with a pop: count becomes DEPTH-1 and in_ready rises the next cycle.
- Empty: out_valid = 0 and out_ready is ignored.
- Two-phase AMO occupies the head for ≥ 2 handshake cycles. Back-to-back ready gives phase 0 then phase 1 on consecutive cycles.
- Reset asserted mid-AMO (phase = 1): the entry is lost and phase returns to 0 immediately.
- Throughput: 1 single-phase instruction per cycle at steady state.

## Test plan
- Reset, then push addi x1,x0,1 (0x00100093) at pc 0x100 → next cycle out_valid=1, out_class=0, out_last=1, count=1; with out_ready=1 → count=0, out_valid=0.
- With DEPTH=4 and out_ready=0, push 5 instructions back-to-back:
  - in_ready drops after the 4th; count=4; the 5th is held by fetch.
  - Pop once: in_ready returns the next cycle; the 5th pushes.
  - Order is preserved across pointer wrap.
- amoadd.w (0x00B5A52F) with out_ready=1:
  - Cycle N: phase=0, last=0.
  - Cycle N+1: phase=1, last=1, same pc.
  - Then pop; the following lr.w (0x1005A52F) shows last=1 in one cycle.
- Illegal cases, each gives out_class=7/4 and out_illegal=1, single phase:
  - opcode 0x7F
  - amoadd.d (funct3=011)
  - amo funct5=11111
- Simultaneous events:
  - Queue holding 2 entries, push and pop in the same cycle → count stays 2.
  - flush with push in the same cycle → count=0 next cycle and the pushed instr is not presented.
- AMO in phase 1 with out_ready=0 and flush=1 → next cycle out_valid=0, phase=0. A subsequent AMO starts at phase 0.
